// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// Tracks E/M/W destination/source shadows, produces stall/flush/forward
// controls, sequences multi-cycle data-memory waits with a timeout, and
// keeps saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              DmemReady,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [WC_W-1:0]     r_wcnt;
  logic                r_mem_err;
  logic [CNT_W-1:0]    r_stall_cnt, r_flush_cnt;

  logic [REG_AW-1:0]   r_rdE, r_rs1E, r_rs2E, r_rdM, r_rdW;
  logic                r_wrE, r_ldE, r_wrM, r_wrW;

  logic                w_memStall, w_lwStall, w_taken, w_timeout;
  logic                w_stallF, w_flushE;

  // Priority chain: memory wait beats a taken branch beats a load-use stall.
  assign w_timeout = (r_wcnt == WC_W'(MEM_TIMEOUT));
  assign w_lwStall = r_ldE && (r_rdE != '0) && ((r_rdE == Rs1D) || (r_rdE == Rs2D));
  assign w_taken   = PCSrcE && !w_memStall;
  assign w_stallF  = w_memStall || (w_lwStall && !w_taken);
  assign w_flushE  = !w_memStall && (w_taken || w_lwStall);

  // Stall/flush outputs are forced low while reset is held.
  assign StallF = !rst && w_stallF;
  assign StallD = !rst && w_stallF;
  assign StallE = !rst && w_memStall;
  assign StallM = !rst && w_memStall;
  assign FlushW = !rst && w_memStall;
  assign FlushD = !rst && w_taken;
  assign FlushE = !rst && w_flushE;

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // M-stage producer is younger than W, so it wins the operand select.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rdM, input logic wrM,
    input logic [REG_AW-1:0] rdW, input logic wrW
  );
    if (wrM && (rdM != '0) && (rdM == rs))      return 2'b10;
    else if (wrW && (rdW != '0) && (rdW == rs)) return 2'b01;
    else                                        return 2'b00;
  endfunction

  assign ForwardAE = rst ? 2'b00 : fwd_sel(r_rs1E, r_rdM, r_wrM, r_rdW, r_wrW);
  assign ForwardBE = rst ? 2'b00 : fwd_sel(r_rs2E, r_rdM, r_wrM, r_rdW, r_wrW);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: enter wait on an unfinished access, leave on ready or timeout
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:     if (MemReqM && !DmemReady) w_state_nxt = MEMWAIT;
      MEMWAIT: if (DmemReady || w_timeout) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // FSM output: memory stall covers the first miss cycle and every wait cycle
  always_comb begin
    w_memStall = 1'b0;
    unique case (r_state)
      RUN:     w_memStall = MemReqM && !DmemReady;
      MEMWAIT: w_memStall = 1'b1;
      default: w_memStall = 1'b0;
    endcase
  end

  // Wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt    <= '0;
      r_mem_err <= 1'b0;
    end else if (r_state == RUN) begin
      if (MemReqM && !DmemReady) r_wcnt <= WC_W'(1);
    end else if (!DmemReady) begin
      if (w_timeout) r_mem_err <= 1'b1;
      else           r_wcnt    <= r_wcnt + WC_W'(1);
    end
  end

  // Shadow pipeline: hold E/M and bubble W on a memory stall, else advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdE <= '0; r_rs1E <= '0; r_rs2E <= '0; r_wrE <= 1'b0; r_ldE <= 1'b0;
      r_rdM <= '0; r_wrM <= 1'b0;
      r_rdW <= '0; r_wrW <= 1'b0;
    end else if (w_memStall) begin
      r_wrW <= 1'b0;
    end else begin
      r_rdW <= r_rdM;
      r_wrW <= r_wrM;
      r_rdM <= r_rdE;
      r_wrM <= r_wrE;
      if (w_flushE) begin
        r_rdE <= '0; r_rs1E <= '0; r_rs2E <= '0; r_wrE <= 1'b0; r_ldE <= 1'b0;
      end else begin
        r_rdE  <= RdD;
        r_rs1E <= Rs1D;
        r_rs2E <= Rs2D;
        r_wrE  <= RegWriteD;
        r_ldE  <= RegWriteD && (ResultSrcD == 2'b01);
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stallF && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_taken  && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test-plan sequences plus randomized traffic,
// checked against a stage-level behavioural model of the controller.
module tb_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int TO    = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] Rs1D = '0, Rs2D = '0, RdD = '0;
  logic RegWriteD = 1'b0, PCSrcE = 1'b0, MemReqM = 1'b0, DmemReady = 1'b0;
  logic [1:0] ResultSrcD = '0;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [6:0] ctl;

  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  hazard_ctrl #(.REG_AW(5), .CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .DmemReady(DmemReady),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: instruction records per stage plus memory-wait bookkeeping.
  typedef struct packed {
    logic [4:0] rd, rs1, rs2;
    logic       wr, ld;
  } ins_t;

  ins_t m_E, m_M, m_W;
  bit   m_inwait, m_err;
  int   m_wait, m_sc, m_fc;

  task automatic mdl_reset();
    m_E = '0; m_M = '0; m_W = '0;
    m_inwait = 0; m_err = 0; m_wait = 0; m_sc = 0; m_fc = 0;
  endtask

  function automatic logic [1:0] fsel(input logic [4:0] rs);
    if (m_M.wr && m_M.rd != 0 && m_M.rd == rs) return 2'b10;
    if (m_W.wr && m_W.rd != 0 && m_W.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Compare this cycle's outputs against the model, then advance it one clock.
  task automatic mdl_cycle();
    bit ms, lw, tk, fe, sf;
    ins_t d;
    ms = m_inwait || (MemReqM && !DmemReady);
    lw = m_E.ld && m_E.rd != 0 && (m_E.rd == Rs1D || m_E.rd == Rs2D);
    tk = PCSrcE && !ms;
    sf = ms || (lw && !tk);
    fe = !ms && (tk || lw);
    chk("ctl", 32'(ctl), 32'({sf, sf, ms, ms, tk, fe, ms}));
    chk("fwd", 32'({ForwardAE, ForwardBE}), 32'({fsel(m_E.rs1), fsel(m_E.rs2)}));
    chk("err", 32'(mem_err), 32'(m_err));
    chk("scnt", 32'(stall_cnt), 32'(m_sc));
    chk("fcnt", 32'(flush_cnt), 32'(m_fc));
    if (sf && m_sc < CMAX) m_sc++;
    if (tk && m_fc < CMAX) m_fc++;
    if (m_inwait) begin
      if (DmemReady) m_inwait = 0;
      else if (m_wait == TO) begin m_err = 1; m_inwait = 0; end
      else m_wait++;
    end else if (MemReqM && !DmemReady) begin
      m_inwait = 1; m_wait = 1;
    end
    if (ms) m_W.wr = 1'b0;
    else begin
      m_W = m_M;
      m_M = m_E;
      d.rd = RdD; d.rs1 = Rs1D; d.rs2 = Rs2D; d.wr = RegWriteD;
      d.ld = RegWriteD && (ResultSrcD == 2'b01);
      m_E = fe ? ins_t'('0) : d;
    end
  endtask

  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic wr, input logic [1:0] rsrc,
                      input logic pcs, input logic mreq, input logic rdy);
    @(negedge clk);
    Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = wr; ResultSrcD = rsrc;
    PCSrcE = pcs; MemReqM = mreq; DmemReady = rdy;
    #1;
    mdl_cycle();
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);
  endtask

  // Asynchronous reset mid-cycle: everything must read zero before the next edge.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_ctl"}, 32'(ctl), 0);
    chk({tag, "_fwd"}, 32'({ForwardAE, ForwardBE}), 0);
    chk({tag, "_err"}, 32'(mem_err), 0);
    chk({tag, "_scnt"}, 32'(stall_cnt), 0);
    chk({tag, "_fcnt"}, 32'(flush_cnt), 0);
    mdl_reset();
    Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 0; ResultSrcD = '0;
    PCSrcE = 0; MemReqM = 0; DmemReady = 1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    mdl_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("por_ctl", 32'(ctl), 0);
    chk("por_scnt", 32'(stall_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // ALU back-to-back, one-bubble and x0 forwarding
    step(1, 2, 5, 1, 2'b00, 0, 0, 1);       // add x5
    step(5, 1, 6, 1, 2'b00, 0, 0, 1);       // sub x6, x5, x1
    nop();  chk("alu_m", 32'(ForwardAE), 2);
    step(1, 2, 9, 1, 2'b00, 0, 0, 1);       // add x9
    nop();
    step(9, 3, 10, 1, 2'b00, 0, 0, 1);      // sub x10, x9, x3
    nop();  chk("alu_w", 32'(ForwardAE), 1);
    step(1, 2, 0, 1, 2'b00, 0, 0, 1);       // add x0
    step(0, 0, 11, 1, 2'b00, 0, 0, 1);      // sub x11, x0, x0
    nop();  chk("x0", 32'(ForwardAE), 0);

    // Load-use: one stall, then W-stage forwarding on both operands
    step(2, 0, 7, 1, 2'b01, 0, 0, 1);       // lw x7
    step(7, 7, 8, 1, 2'b00, 0, 0, 1);       // add x8, x7, x7
    chk("lu_ctl", 32'(ctl), 32'(7'b1100010));
    step(7, 7, 8, 1, 2'b00, 0, 0, 1);       // re-presented after the stall
    chk("lu_scnt", 32'(stall_cnt), 1);
    nop();  chk("lu_fwd", 32'({ForwardAE, ForwardBE}), 32'(4'b0101));

    // Taken branch coinciding with load-use
    step(2, 0, 12, 1, 2'b01, 0, 0, 1);      // lw x12
    step(12, 0, 13, 1, 2'b00, 1, 0, 1);     // add x13, x12 with PCSrcE
    chk("br_ctl", 32'(ctl), 32'(7'b0000110));
    nop();  chk("br_fcnt", 32'(flush_cnt), 1);
    chk("br_scnt", 32'(stall_cnt), 1);

    // Multi-cycle memory wait: 3 not-ready cycles then ready
    step(1, 2, 14, 1, 2'b00, 0, 0, 1);      // add x14
    step(14, 14, 15, 1, 2'b00, 0, 0, 1);    // add x15, x14, x14
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 2'b00, (i == 1), 1, (i == 3));
      chk("mw_ctl", 32'(ctl), 32'(7'b1111001));
    end
    nop();
    chk("mw_rel", 32'(ctl), 0);
    chk("mw_hold", 32'({ForwardAE, ForwardBE}), 32'(4'b1010));
    chk("mw_scnt", 32'(stall_cnt), 5);

    // Reset in the middle of a memory wait
    step(0, 0, 0, 0, 2'b00, 0, 1, 0);
    step(0, 0, 0, 0, 2'b00, 0, 1, 0);
    async_reset("rst_mw");
    nop();  chk("rst_run", 32'(ctl), 0);

    // Timeout: mem_err rises after the 4th wait-state cycle, stall then releases
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 2'b00, 0, 1, 0);
      chk("to_err0", 32'(mem_err), 0);
    end
    nop();
    chk("to_err1", 32'(mem_err), 1);
    chk("to_rel", 32'(StallF), 0);
    nop();  chk("to_sticky", 32'(mem_err), 1);

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 9) < ((n % 400) < 200 ? 7 : 3)));
      if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
    end

    async_reset("end_rst");
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
